axil_regfile_slave: RTL
=======================

// Module: axil_regfile_slave
// PURPOSE
//  AXI4-Lite responder that terminates the five channels driven by Master_Interface.
//  Holds a bank of NUM_REGS software-visible registers with byte-strobed writes.
//  Returns OKAY/SLVERR responses on the B and R channels.
//  Read and write paths are independent FSMs that can run in the same cycle.
//  Intended as the standard slave endpoint in AXI-Lite integration benches and SoC tops.
// PARAMETERS
//  REG_WIDTH   32  data width; must be 32 (4 byte lanes)
//  ADDR_WIDTH  32  AWADDR/ARADDR width
//  NUM_REGS    16  register count; power of 2, >= 2
// PORTS
//  ACLK       in   1                    clock; all logic on posedge
//  ARESETN    in   1                    synchronous reset, active low
//  AWADDR     in   ADDR_WIDTH           write byte address
//  AWVALID    in   1                    write address valid
//  AWREADY    out  1                    write address ready
//  WDATA      in   REG_WIDTH            write data
//  WSTRB      in   REG_WIDTH/8          byte-lane enables
//  WVALID     in   1                    write data valid
//  WREADY     out  1                    write data ready
//  BRESP      out  2                    write response: 2'b00 OKAY, 2'b10 SLVERR
//  BVALID     out  1                    write response valid
//  BREADY     in   1                    write response ready
//  ARADDR     in   ADDR_WIDTH           read byte address
//  ARVALID    in   1                    read address valid
//  ARREADY    out  1                    read address ready
//  RDATA      out  REG_WIDTH            read data
//  RRESP      out  2                    read response; same encoding as BRESP
//  RVALID     out  1                    read data valid
//  RREADY     in   1                    read data ready
//  REGS_FLAT  out  NUM_REGS*REG_WIDTH   live register contents; reg i at [i*REG_WIDTH +: REG_WIDTH]
// BEHAVIOUR
//  Reset (ARESETN=0 at posedge):
//   - all registers, RDATA, BRESP and RRESP cleared to 0
//   - BVALID=RVALID=0; both FSMs return to IDLE
//   - a write not yet committed is discarded; a pending response is dropped
//  Decode:
//   - index = ADDR[$clog2(NUM_REGS)+1:2]; ADDR[1:0] ignored
//   - ADDR >= NUM_REGS*4 -> SLVERR; such a write changes no register; such a read returns RDATA=0
//  Write FSM states: W_IDLE, W_ADDR (AW held), W_DATA (W held), W_RESP.
//   - AWREADY = state in {W_IDLE, W_DATA}; WREADY = state in {W_IDLE, W_ADDR} (decoded from state only)
//   - W_IDLE: AW and W in the same cycle -> W_RESP; AW only -> W_ADDR (latch AWADDR); W only -> W_DATA (latch WDATA, WSTRB)
//   - W_ADDR: W handshake -> W_RESP; W_DATA: AW handshake -> W_RESP
//   - Commit and response on the edge entering W_RESP:
//     - register bytes are updated where WSTRB[b]=1
//     - BVALID=1 and BRESP are valid the next cycle, i.e. 1 cycle after the last handshake
//   - W_RESP: BVALID and BRESP held stable until BREADY=1; that edge -> W_IDLE with BVALID=0
//   - New AW/W is accepted only back in W_IDLE; minimum 2 cycles per write with BREADY tied high
//  Read FSM states: R_IDLE, R_RESP.
//   - ARREADY = (state==R_IDLE)
//   - AR handshake -> RDATA/RRESP registered, RVALID=1 next cycle (latency 1)
//   - RDATA, RRESP and RVALID held until RREADY=1; that edge -> R_IDLE with RVALID=0
//  Simultaneous events:
//   - a read sampled on the same edge as a write commit to the same register returns the pre-write value
//   - REGS_FLAT reflects a commit the cycle after the commit edge
//  No outstanding-transaction depth: at most 1 write and 1 read in flight.
// TESTING
//  1. Reset, then AW=0x08 and W=0x0000_2564 with WSTRB=4'hF in the same cycle, BREADY=1 -> AWREADY=WREADY=1 that cycle; BVALID=1, BRESP=00 next cycle; REGS_FLAT[95:64]=0x2564.
//  2. W (0xDEAD_BEEF, WSTRB=4'b0101) 3 cycles before AW=0x04, then AR=0x04 -> reg1=0x00AD_00EF; RVALID 1 cycle after AR, RDATA=0x00AD_00EF, RRESP=00.
//  3. AW=0x40 (out of range for 16 regs) with W=0xFFFF_FFFF -> BRESP=10, REGS_FLAT unchanged; AR=0x40 -> RRESP=10, RDATA=0.
//  4. BREADY=0 for 5 cycles after a write -> BVALID/BRESP stable for all 5 cycles, AWREADY=WREADY=0; BREADY=1 -> BVALID=0 next cycle, ready lines high again.
//  5. Same edge: write 0x1111 to 0x0C and AR=0x0C, reg3 previously 0 -> RDATA=0; a following read returns 0x1111.
//  6. ARESETN=0 while in W_ADDR and in R_RESP (RREADY=0) -> next cycle BVALID=RVALID=0, all REGS_FLAT=0, AWREADY=WREADY=ARREADY=1.

Source files
------------

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave that terminates AW/W/B/AR/R and exposes a bank of byte-strobed registers.
// Ports:
//   ACLK, ARESETN            clock and synchronous active-low reset
//   AWADDR/AWVALID/AWREADY   write address channel
//   WDATA/WSTRB/WVALID/WREADY write data channel
//   BRESP/BVALID/BREADY      write response channel (00 OKAY, 10 SLVERR)
//   ARADDR/ARVALID/ARREADY   read address channel
//   RDATA/RRESP/RVALID/RREADY read data channel
//   REGS_FLAT                live register contents, reg i at [i*REG_WIDTH +: REG_WIDTH]
module axil_regfile_slave #(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [ADDR_WIDTH-1:0]           AWADDR,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [REG_WIDTH-1:0]            WDATA,
  input  logic [REG_WIDTH/8-1:0]          WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [ADDR_WIDTH-1:0]           ARADDR,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [REG_WIDTH-1:0]            RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [NUM_REGS*REG_WIDTH-1:0]   REGS_FLAT
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned STRB_W = REG_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic [REG_WIDTH-1:0] regs_q [NUM_REGS];

  logic [IDX_W-1:0]     aw_idx_q;
  logic                 aw_err_q;
  logic [REG_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]    w_strb_q;
  logic [1:0]           bresp_q;
  logic [REG_WIDTH-1:0] rdata_q;
  logic [1:0]           rresp_q;

  // Address decode; any bit above the register window means out of range.
  logic [IDX_W-1:0] aw_idx_c, ar_idx_c;
  logic             aw_err_c, ar_err_c;
  assign aw_idx_c = AWADDR[IDX_W+1:2];
  assign ar_idx_c = ARADDR[IDX_W+1:2];
  assign aw_err_c = |AWADDR[ADDR_WIDTH-1:IDX_W+2];
  assign ar_err_c = |ARADDR[ADDR_WIDTH-1:IDX_W+2];

  // Byte offset within a word is irrelevant to a word-wide register bank.
  logic unused_c;
  assign unused_c = ^{AWADDR[1:0], ARADDR[1:0]};

  // Handshake readiness is a pure function of state.
  assign AWREADY = (w_state_q == W_IDLE) || (w_state_q == W_DATA);
  assign WREADY  = (w_state_q == W_IDLE) || (w_state_q == W_ADDR);
  assign BVALID  = (w_state_q == W_RESP);
  assign BRESP   = bresp_q;
  assign ARREADY = (r_state_q == R_IDLE);
  assign RVALID  = (r_state_q == R_RESP);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  // Write FSM next state plus commit selection: each half comes from the live bus or its latch.
  logic                 commit_c;
  logic [IDX_W-1:0]     cm_idx_c;
  logic                 cm_err_c;
  logic [REG_WIDTH-1:0] cm_data_c;
  logic [STRB_W-1:0]    cm_strb_c;

  always_comb begin
    w_state_d = w_state_q;
    commit_c  = 1'b0;
    cm_idx_c  = aw_idx_c;
    cm_err_c  = aw_err_c;
    cm_data_c = WDATA;
    cm_strb_c = WSTRB;
    unique case (w_state_q)
      W_IDLE: begin
        if (AWVALID && WVALID) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end else if (AWVALID) begin
          w_state_d = W_ADDR;
        end else if (WVALID) begin
          w_state_d = W_DATA;
        end
      end
      W_ADDR: begin
        cm_idx_c = aw_idx_q;
        cm_err_c = aw_err_q;
        if (WVALID) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end
      end
      W_DATA: begin
        cm_data_c = w_data_q;
        cm_strb_c = w_strb_q;
        if (AWVALID) begin
          w_state_d = W_RESP;
          commit_c  = 1'b1;
        end
      end
      W_RESP: begin
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state.
  logic ar_hs_c;
  assign ar_hs_c = (r_state_q == R_IDLE) && ARVALID;

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ARVALID) r_state_d = R_RESP;
      R_RESP:  if (RREADY)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  // Write datapath: latch the early half, commit strobed bytes, register the response.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      aw_idx_q <= '0;
      aw_err_q <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (w_state_q == W_IDLE && AWVALID && !WVALID) begin
        aw_idx_q <= aw_idx_c;
        aw_err_q <= aw_err_c;
      end
      if (w_state_q == W_IDLE && WVALID && !AWVALID) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (commit_c) begin
        if (!cm_err_c) begin
          for (int b = 0; b < int'(STRB_W); b++) begin
            if (cm_strb_c[b]) regs_q[cm_idx_c][8*b +: 8] <= cm_data_c[8*b +: 8];
          end
        end
        bresp_q <= cm_err_c ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Read datapath: sample the bank on the AR edge, so a same-edge commit is not yet visible.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs_c) begin
      rdata_q <= ar_err_c ? '0 : regs_q[ar_idx_c];
      rresp_q <= ar_err_c ? RESP_SLVERR : RESP_OKAY;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign REGS_FLAT[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
  end

endmodule
